// File: rtl/truth_table_scanner.sv
// -----------------------------------------------------------------------------
// truth_table_scanner
//
// Walks a downstream 3-input combinational stage through input vectors
// 0 .. NVEC-1, holding each vector for HOLD_CYCLES clocks and capturing the
// stage response o into result[index] on the last held cycle.
//
// Parameters
//   NVEC         number of 3-bit vectors scanned (1..8)
//   HOLD_CYCLES  clocks each vector is held before o is sampled (1..15)
//
// Ports
//   clk         in   single clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   start       in   scan request, honoured only in IDLE
//   abort       in   synchronous cancel, effective only while driving
//   o           in   response of the downstream stage
//   a, b, c     out  stimulus to the downstream stage ({a,b,c} = index)
//   busy        out  high while vectors are being driven
//   done        out  one-cycle pulse when a scan completes
//   result      out  bit i holds o captured for vector i
//
// Optional feature (macro SCAN_COMPARE_EN):
//   expected    in   golden response pattern
//   mismatch    out  any masked difference between result and expected
//   first_fail  out  lowest failing vector index (0 when none)
// -----------------------------------------------------------------------------
module truth_table_scanner #(
    parameter int NVEC        = 8,
    parameter int HOLD_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       o,
`ifdef SCAN_COMPARE_EN
    input  logic [7:0] expected,
    output logic       mismatch,
    output logic [2:0] first_fail,
`endif
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic [7:0] result
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [2:0] LAST_IDX  = 3'(NVEC - 1);
    localparam logic [3:0] LAST_HOLD = 4'(HOLD_CYCLES - 1);

    state_t     r_state;
    logic [2:0] r_index;
    logic [3:0] r_hold;
    logic [7:0] r_result;

    state_t     w_state_nxt;
    logic [2:0] w_index_nxt;
    logic [3:0] w_hold_nxt;
    logic [7:0] w_result_nxt;
    logic       w_clr;       // scan accepted or aborted: clear compare status
    logic       w_finish;    // last vector sampled this edge

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath next values
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_index_nxt  = r_index;
        w_hold_nxt   = r_hold;
        w_result_nxt = r_result;
        w_clr        = 1'b0;
        w_finish     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt  = S_DRIVE;
                    w_index_nxt  = 3'd0;
                    w_hold_nxt   = 4'd0;
                    w_result_nxt = 8'd0;
                    w_clr        = 1'b1;
                end
            end

            S_DRIVE: begin
                // Abort wins over the sampling edge: the current vector is
                // not captured and no done pulse is produced.
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_index_nxt = 3'd0;
                    w_hold_nxt  = 4'd0;
                    w_clr       = 1'b1;
                end else if (r_hold == LAST_HOLD) begin
                    w_hold_nxt            = 4'd0;
                    w_result_nxt[r_index] = o;
                    if (r_index < LAST_IDX) begin
                        w_index_nxt = r_index + 3'd1;
                    end else begin
                        w_index_nxt = 3'd0;
                        w_state_nxt = S_DONE;
                        w_finish    = 1'b1;
                    end
                end else begin
                    w_hold_nxt = r_hold + 4'd1;
                end
            end

            S_DONE: begin
                // Single-cycle completion marker; start is ignored here.
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_index_nxt = 3'd0;
                w_hold_nxt  = 4'd0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_index  <= 3'd0;
            r_hold   <= 4'd0;
            r_result <= 8'd0;
        end else begin
            r_index  <= w_index_nxt;
            r_hold   <= w_hold_nxt;
            r_result <= w_result_nxt;
        end
    end

`ifdef SCAN_COMPARE_EN
    // -------------------------------------------------------------------------
    // Golden compare: evaluated on the completing edge using the result
    // value that includes the final sample, so it is valid during DONE.
    // -------------------------------------------------------------------------
    localparam logic [7:0] MASK = 8'((9'd1 << NVEC) - 9'd1);

    logic [7:0] w_fail_vec;
    logic [2:0] w_first;
    logic       r_mismatch;
    logic [2:0] r_first_fail;

    always_comb begin
        w_fail_vec = (w_result_nxt ^ expected) & MASK;
        w_first    = 3'd0;
        // Descending scan so the lowest set bit is the one that sticks.
        for (int i = 7; i >= 0; i--) begin
            if (w_fail_vec[i]) begin
                w_first = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mismatch   <= 1'b0;
            r_first_fail <= 3'd0;
        end else if (w_clr) begin
            r_mismatch   <= 1'b0;
            r_first_fail <= 3'd0;
        end else if (w_finish) begin
            r_mismatch   <= |w_fail_vec;
            r_first_fail <= w_first;
        end
    end

    assign mismatch   = r_mismatch;
    assign first_fail = r_first_fail;
`endif

    // -------------------------------------------------------------------------
    // Outputs: decoded from registered state so reset clears them at once.
    // -------------------------------------------------------------------------
    logic w_driving;
    assign w_driving = (r_state == S_DRIVE);

    assign busy      = w_driving;
    assign done      = (r_state == S_DONE);
    assign {a, b, c} = w_driving ? r_index : 3'b000;
    assign result    = r_result;

endmodule

// File: tb/tb_truth_table_scanner.sv
module tb_truth_table_scanner;

    logic clk;
    logic rst_n;

    // dut0: defaults, o selectable between AND and NAND
    logic       start0, abort0, fsel0, o0;
    logic       a0, b0, c0, busy0, done0;
    logic [7:0] result0;
    // dut1: HOLD_CYCLES=2, o = XOR
    logic       start1, abort1, o1;
    logic       a1, b1, c1, busy1, done1;
    logic [7:0] result1;
    // dut2: NVEC=4, o = b|c
    logic       start2, abort2, o2;
    logic       a2, b2, c2, busy2, done2;
    logic [7:0] result2;
`ifdef SCAN_COMPARE_EN
    logic [7:0] expected0, expected1, expected2;
    logic       mismatch0, mismatch1, mismatch2;
    logic [2:0] first_fail0, first_fail1, first_fail2;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    assign o0 = fsel0 ? ~(a0 & b0 & c0) : (a0 & b0 & c0);
    assign o1 = a1 ^ b1 ^ c1;
    assign o2 = b2 | c2;

    truth_table_scanner dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .o(o0),
`ifdef SCAN_COMPARE_EN
        .expected(expected0), .mismatch(mismatch0), .first_fail(first_fail0),
`endif
        .a(a0), .b(b0), .c(c0), .busy(busy0), .done(done0), .result(result0)
    );

    truth_table_scanner #(.NVEC(8), .HOLD_CYCLES(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .o(o1),
`ifdef SCAN_COMPARE_EN
        .expected(expected1), .mismatch(mismatch1), .first_fail(first_fail1),
`endif
        .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .result(result1)
    );

    truth_table_scanner #(.NVEC(4), .HOLD_CYCLES(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .o(o2),
`ifdef SCAN_COMPARE_EN
        .expected(expected2), .mismatch(mismatch2), .first_fail(first_fail2),
`endif
        .a(a2), .b(b2), .c(c2), .busy(busy2), .done(done2), .result(result2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_tests++;
        if ({a0, b0, c0, busy0, done0, result0} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_dut0 got=%h exp=0", {a0, b0, c0, busy0, done0, result0});
        end
        n_tests++;
        if ({a1, b1, c1, busy1, done1, result1} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_dut1 got=%h exp=0", {a1, b1, c1, busy1, done1, result1});
        end
        n_tests++;
        if ({a2, b2, c2, busy2, done2, result2} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_dut2 got=%h exp=0", {a2, b2, c2, busy2, done2, result2});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // o = a&b&c with defaults: 8 busy cycles, vectors in order, result 0x80
    task automatic test_and_defaults();
        fsel0  = 1'b0;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (busy0 !== 1'b1 || done0 !== 1'b0 || {a0, b0, c0} !== 3'(i)) begin
                n_fail++;
                $display("FAIL and_vec%0d got busy=%b done=%b abc=%0d exp busy=1 done=0 abc=%0d",
                         i, busy0, done0, {a0, b0, c0}, i);
            end
            @(negedge clk);
        end
        n_tests++;
        if (done0 !== 1'b1 || busy0 !== 1'b0 || {a0, b0, c0} !== 3'd0 || result0 !== 8'h80) begin
            n_fail++;
            $display("FAIL and_done got done=%b busy=%b abc=%0d result=%h exp done=1 busy=0 abc=0 result=80",
                     done0, busy0, {a0, b0, c0}, result0);
        end
        @(negedge clk);
        n_tests++;
        if (done0 !== 1'b0 || busy0 !== 1'b0 || result0 !== 8'h80) begin
            n_fail++;
            $display("FAIL and_after got done=%b busy=%b result=%h exp done=0 busy=0 result=80",
                     done0, busy0, result0);
        end
    endtask

    // o = a^b^c, HOLD_CYCLES=2: 16 busy cycles, result 0x96
    task automatic test_xor_hold2();
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            n_tests++;
            if (busy1 !== 1'b1 || {a1, b1, c1} !== 3'(i / 2)) begin
                n_fail++;
                $display("FAIL xor_cyc%0d got busy=%b abc=%0d exp busy=1 abc=%0d",
                         i, busy1, {a1, b1, c1}, i / 2);
            end
            @(negedge clk);
        end
        n_tests++;
        if (done1 !== 1'b1 || busy1 !== 1'b0 || result1 !== 8'h96) begin
            n_fail++;
            $display("FAIL xor_done got done=%b busy=%b result=%h exp done=1 busy=0 result=96",
                     done1, busy1, result1);
        end
        @(negedge clk);
    endtask

    // NVEC=4, o = b|c: 4 busy cycles, result 0x0E
    task automatic test_nvec4();
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (busy2 !== 1'b1 || {a2, b2, c2} !== 3'(i)) begin
                n_fail++;
                $display("FAIL nvec4_vec%0d got busy=%b abc=%0d exp busy=1 abc=%0d",
                         i, busy2, {a2, b2, c2}, i);
            end
            @(negedge clk);
        end
        n_tests++;
        if (done2 !== 1'b1 || busy2 !== 1'b0 || {a2, b2, c2} !== 3'd0 || result2 !== 8'h0E) begin
            n_fail++;
            $display("FAIL nvec4_done got done=%b busy=%b abc=%0d result=%h exp done=1 busy=0 abc=0 result=0e",
                     done2, busy2, {a2, b2, c2}, result2);
        end
        @(negedge clk);
    endtask

    // Abort on vector 3 (o=NAND so bits 0..2 are 1 and bit 3 would be 1)
    task automatic test_abort();
        fsel0  = 1'b1;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({a0, b0, c0} !== 3'd3 || busy0 !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_pre got abc=%0d busy=%b exp abc=3 busy=1", {a0, b0, c0}, busy0);
        end
        abort0 = 1'b1;
        @(negedge clk);
        abort0 = 1'b0;
        n_tests++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || {a0, b0, c0} !== 3'd0 || result0 !== 8'h07) begin
            n_fail++;
            $display("FAIL abort_post got busy=%b done=%b abc=%0d result=%h exp busy=0 done=0 abc=0 result=07",
                     busy0, done0, {a0, b0, c0}, result0);
        end
        // abort in IDLE must not disturb anything
        abort0 = 1'b1;
        @(negedge clk);
        abort0 = 1'b0;
        n_tests++;
        if (done0 !== 1'b0 || busy0 !== 1'b0 || result0 !== 8'h07) begin
            n_fail++;
            $display("FAIL abort_idle got done=%b busy=%b result=%h exp done=0 busy=0 result=07",
                     done0, busy0, result0);
        end
        test_and_defaults();
    endtask

    // Reset during vector 5, then start held through busy and DONE
    task automatic test_reset_mid();
        fsel0  = 1'b1;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (5) @(negedge clk);
        n_tests++;
        if ({a0, b0, c0} !== 3'd5 || result0 !== 8'h1F) begin
            n_fail++;
            $display("FAIL rst_pre got abc=%0d result=%h exp abc=5 result=1f", {a0, b0, c0}, result0);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({a0, b0, c0, busy0, done0, result0} !== 13'd0) begin
            n_fail++;
            $display("FAIL rst_mid got=%h exp=0", {a0, b0, c0, busy0, done0, result0});
        end
        @(negedge clk);
        rst_n  = 1'b1;
        start0 = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (busy0 !== 1'b1 || {a0, b0, c0} !== 3'(i)) begin
                n_fail++;
                $display("FAIL hold_vec%0d got busy=%b abc=%0d exp busy=1 abc=%0d",
                         i, busy0, {a0, b0, c0}, i);
            end
            @(negedge clk);
        end
        n_tests++;
        if (done0 !== 1'b1 || busy0 !== 1'b0 || result0 !== 8'h7F) begin
            n_fail++;
            $display("FAIL hold_done got done=%b busy=%b result=%h exp done=1 busy=0 result=7f",
                     done0, busy0, result0);
        end
        @(negedge clk);
        n_tests++;
        if (busy0 !== 1'b0 || done0 !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_nostart got busy=%b done=%b exp busy=0 done=0", busy0, done0);
        end
        start0 = 1'b0;
        @(negedge clk);
        n_tests++;
        if (busy0 !== 1'b0 || result0 !== 8'h7F) begin
            n_fail++;
            $display("FAIL hold_idle got busy=%b result=%h exp busy=0 result=7f", busy0, result0);
        end
    endtask

`ifdef SCAN_COMPARE_EN
    task automatic test_compare();
        fsel0     = 1'b0;
        expected0 = 8'h81;
        start0    = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (8) @(negedge clk);
        n_tests++;
        if (done0 !== 1'b1 || mismatch0 !== 1'b1 || first_fail0 !== 3'd0) begin
            n_fail++;
            $display("FAIL cmp_81 got done=%b mismatch=%b first=%0d exp done=1 mismatch=1 first=0",
                     done0, mismatch0, first_fail0);
        end
        @(negedge clk);
        expected0 = 8'h80;
        start0    = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (8) @(negedge clk);
        n_tests++;
        if (done0 !== 1'b1 || mismatch0 !== 1'b0 || first_fail0 !== 3'd0) begin
            n_fail++;
            $display("FAIL cmp_80 got done=%b mismatch=%b first=%0d exp done=1 mismatch=0 first=0",
                     done0, mismatch0, first_fail0);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        start0 = 1'b0; abort0 = 1'b0; fsel0 = 1'b0;
        start1 = 1'b0; abort1 = 1'b0;
        start2 = 1'b0; abort2 = 1'b0;
`ifdef SCAN_COMPARE_EN
        expected0 = 8'h00; expected1 = 8'h00; expected2 = 8'h00;
`endif
        test_reset();
        test_and_defaults();
        @(negedge clk);
        test_xor_hold2();
        test_nvec4();
        test_abort();
        @(negedge clk);
        test_reset_mid();
`ifdef SCAN_COMPARE_EN
        test_compare();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
